// File: rtl/chronos.sv
// Shared chronos tile definitions: tile ids, NoC beat payload and small sizing helpers.
package chronos;

  localparam int unsigned TILE_ID_W       = 4;
  localparam int unsigned NOC_DATA_W      = 32;
  localparam int unsigned NOC_STALL_CNT_W = 32;

  typedef logic [TILE_ID_W-1:0] tile_id_t;

  typedef struct packed {
    logic [NOC_DATA_W-1:0] data;
    tile_id_t              dst;
    logic                  last;
  } noc_beat_t;

  // Message-lock state of a NoC port arbiter
  typedef enum logic {
    LK_OPEN = 1'b0,
    LK_HELD = 1'b1
  } lock_state_e;

  // Index width that stays legal (>=1 bit) for single-entry arbiters
  function automatic int unsigned id_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter with a lock override; priority starts at ptr+1.
module rr_arbiter
  import chronos::*;
#(
  parameter  int unsigned N    = 4,
  localparam int unsigned ID_W = id_width(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  input  logic            lock,
  input  logic [ID_W-1:0] lock_id,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id
);

  logic [ID_W-1:0] scan_idx;
  logic            found;

  // First requester after ptr wins unless a locked message owns the port
  always_comb begin
    gnt      = '0;
    gnt_id   = '0;
    scan_idx = '0;
    found    = 1'b0;
    if (lock) begin
      gnt_id = lock_id;
      if (req[lock_id]) begin
        gnt[lock_id] = 1'b1;
      end
    end else begin
      for (int unsigned i = 1; i <= N; i++) begin
        scan_idx = ID_W'((32'(ptr) + i) % N);
        if (!found && req[scan_idx]) begin
          found         = 1'b1;
          gnt[scan_idx] = 1'b1;
          gnt_id        = scan_idx;
        end
      end
    end
  end

endmodule

// File: rtl/noc_port_arbiter.sv
// Shares one tile_noc slave port among NUM_REQ requesters with per-message locking,
// a single registered output stage and a saturating back-pressure counter.
module noc_port_arbiter
  import chronos::*;
#(
  parameter  int unsigned NUM_REQ    = 4,
  parameter  int unsigned DATA_WIDTH = 32,
  localparam int unsigned ID_W       = id_width(NUM_REQ)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic [NUM_REQ-1:0]                  req_valid,
  output logic [NUM_REQ-1:0]                  req_ready,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]  req_data,
  input  tile_id_t [NUM_REQ-1:0]              req_dst,
  input  logic [NUM_REQ-1:0]                  req_last,
  output logic                                s_wvalid,
  input  logic                                s_wready,
  output logic [DATA_WIDTH-1:0]               s_wdata,
  output tile_id_t                            s_port,
  output logic [ID_W-1:0]                     grant_id,
  output logic [NOC_STALL_CNT_W-1:0]          stall_cycles
);

  lock_state_e         lock_state, lock_state_next;
  logic [ID_W-1:0]     lock_id, lock_id_next;
  logic [ID_W-1:0]     rr_ptr, rr_ptr_next;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     win_id;
  logic                lock_held;
  logic                free_c;
  logic                accept_c;

  assign lock_held = (lock_state == LK_HELD);

  rr_arbiter #(
    .N (NUM_REQ)
  ) u_rr_arbiter (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .lock    (lock_held),
    .lock_id (lock_id),
    .gnt     (gnt),
    .gnt_id  (win_id)
  );

  // Output register can take a beat when empty or draining this cycle
  assign free_c    = !s_wvalid || s_wready;
  assign req_ready = free_c ? gnt : '0;
  assign accept_c  = |req_ready;

  // Lock state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_state <= LK_OPEN;
      lock_id    <= '0;
      rr_ptr     <= ID_W'(NUM_REQ - 1);
    end else begin
      lock_state <= lock_state_next;
      lock_id    <= lock_id_next;
      rr_ptr     <= rr_ptr_next;
    end
  end

  // Lock opens on a last beat; the rr pointer only moves per message
  always_comb begin
    lock_state_next = lock_state;
    lock_id_next    = lock_id;
    rr_ptr_next     = rr_ptr;
    if (accept_c) begin
      if (req_last[win_id]) begin
        lock_state_next = LK_OPEN;
        rr_ptr_next     = win_id;
      end else begin
        lock_state_next = LK_HELD;
        lock_id_next    = win_id;
      end
    end
  end

  // Output stage: load on accept, clear on drain without a replacement
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_wvalid <= 1'b0;
      s_wdata  <= '0;
      s_port   <= '0;
      grant_id <= '0;
    end else if (accept_c) begin
      s_wvalid <= 1'b1;
      s_wdata  <= req_data[win_id];
      s_port   <= req_dst[win_id];
      grant_id <= win_id;
    end else if (s_wready) begin
      s_wvalid <= 1'b0;
    end
  end

  // Saturating back-pressure counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cycles <= '0;
    end else if (s_wvalid && !s_wready && (stall_cycles != '1)) begin
      stall_cycles <= stall_cycles + NOC_STALL_CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_noc_port_arbiter.sv
// Scoreboard bench for noc_port_arbiter: queued requester streams, expected beat order checked at the port.
module tb_noc_port_arbiter;
  import chronos::*;

  localparam int unsigned NR = 4;
  localparam int unsigned DW = 32;

  logic                     clk = 1'b0;
  logic                     rst = 1'b1;
  logic [NR-1:0]            req_valid;
  logic [NR-1:0]            req_ready;
  logic [NR-1:0][DW-1:0]    req_data;
  tile_id_t [NR-1:0]        req_dst;
  logic [NR-1:0]            req_last;
  logic                     s_wvalid;
  logic                     s_wready;
  logic [DW-1:0]            s_wdata;
  tile_id_t                 s_port;
  logic [1:0]               grant_id;
  logic [31:0]              stall_cycles;

  always #5 clk = ~clk;

  noc_port_arbiter #(
    .NUM_REQ    (NR),
    .DATA_WIDTH (DW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_data     (req_data),
    .req_dst      (req_dst),
    .req_last     (req_last),
    .s_wvalid     (s_wvalid),
    .s_wready     (s_wready),
    .s_wdata      (s_wdata),
    .s_port       (s_port),
    .grant_id     (grant_id),
    .stall_cycles (stall_cycles)
  );

  typedef struct {
    logic [DW-1:0] data;
    tile_id_t      dst;
    logic          last;
    int            pre;
  } beat_t;

  typedef struct {
    logic [1:0]    id;
    logic [DW-1:0] data;
    tile_id_t      dst;
  } exp_t;

  beat_t bq [NR][$];
  exp_t  sb [$];
  int    n_checks = 0;
  int    n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic send(input int r, input logic [DW-1:0] d, input tile_id_t dst,
                      input logic last, input int pre);
    beat_t b;
    b.data = d;
    b.dst  = dst;
    b.last = last;
    b.pre  = pre;
    bq[r].push_back(b);
  endtask

  task automatic expect_beat(input int r, input logic [DW-1:0] d, input tile_id_t dst);
    exp_t e;
    e.id   = 2'(r);
    e.data = d;
    e.dst  = dst;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    s_wready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  function automatic int pending();
    int n;
    n = sb.size();
    for (int r = 0; r < NR; r++) n += bq[r].size();
    return n;
  endfunction

  task automatic wait_idle(input string tag);
    int cyc;
    cyc = 0;
    while (pending() != 0 && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({tag, "_drained"}, 64'(pending()), 0);
  endtask

  // Requester driver: presents queue heads after optional idle gaps, pops on handshake
  initial begin
    logic [NR-1:0] hs;
    logic [NR-1:0] started;
    int            idle [NR];
    req_valid = '0;
    req_data  = '0;
    req_dst   = '0;
    req_last  = '0;
    started   = '0;
    for (int r = 0; r < NR; r++) idle[r] = 0;
    forever begin
      @(negedge clk);
      hs = req_valid & req_ready;
      @(posedge clk);
      #1;
      for (int r = 0; r < NR; r++) begin
        if (rst) begin
          bq[r].delete();
          started[r]   = 1'b0;
          req_valid[r] = 1'b0;
        end else begin
          if (hs[r] && bq[r].size() != 0) begin
            void'(bq[r].pop_front());
            started[r] = 1'b0;
          end
          req_valid[r] = 1'b0;
          if (bq[r].size() != 0) begin
            if (!started[r]) begin
              idle[r]    = bq[r][0].pre;
              started[r] = 1'b1;
            end
            if (idle[r] > 0) begin
              idle[r]--;
            end else begin
              req_valid[r] = 1'b1;
              req_data[r]  = bq[r][0].data;
              req_dst[r]   = bq[r][0].dst;
              req_last[r]  = bq[r][0].last;
            end
          end
        end
      end
    end
  end

  // Port monitor: scoreboard compare plus grant exclusivity under a message lock
  initial begin
    logic          mlocked;
    logic [1:0]    mlock_id;
    logic [NR-1:0] hs;
    exp_t          e;
    mlocked  = 1'b0;
    mlock_id = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        mlocked = 1'b0;
        sb.delete();
      end else begin
        check_eq("ready_onehot", 64'($onehot0(req_ready)), 1);
        check_eq("ready_needs_valid", 64'(req_ready & ~req_valid), 0);
        if (mlocked) check_eq("lock_excl", 64'(req_ready & ~(NR'(1) << mlock_id)), 0);
        if (s_wvalid && s_wready) begin
          check_eq("sb_nonempty", 64'(sb.size() != 0), 1);
          if (sb.size() != 0) begin
            e = sb.pop_front();
            check_eq("beat_id", 64'(grant_id), 64'(e.id));
            check_eq("beat_data", 64'(s_wdata), 64'(e.data));
            check_eq("beat_port", 64'(s_port), 64'(e.dst));
          end
        end
        hs = req_valid & req_ready;
        for (int r = 0; r < NR; r++) begin
          if (hs[r]) begin
            mlocked  = !req_last[r];
            mlock_id = 2'(r);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1);
  end

  initial begin
    int   cyc;
    int   cnt;
    logic found;
    s_wready = 1'b1;
    do_reset();

    // Reset values
    check_eq("rst_wvalid", 64'(s_wvalid), 0);
    check_eq("rst_wdata", 64'(s_wdata), 0);
    check_eq("rst_port", 64'(s_port), 0);
    check_eq("rst_grant", 64'(grant_id), 0);
    check_eq("rst_stall", 64'(stall_cycles), 0);
    check_eq("rst_ready", 64'(req_ready), 0);

    // Single beat from requester 0, one-cycle latency
    send(0, 32'hFFFF_FFFF, 4'd1, 1'b1, 0);
    expect_beat(0, 32'hFFFF_FFFF, 4'd1);
    @(negedge clk);
    check_eq("t1_ready", 64'(req_ready), 64'(4'b0001));
    @(negedge clk);
    check_eq("t1_wvalid", 64'(s_wvalid), 1);
    check_eq("t1_port", 64'(s_port), 1);
    check_eq("t1_data", 64'(s_wdata), 64'(32'hFFFF_FFFF));
    check_eq("t1_grant", 64'(grant_id), 0);
    wait_idle("t1");

    // All requesters busy with single beats: strict rotation, no bubbles
    do_reset();
    for (int k = 0; k < 2; k++) begin
      for (int r = 0; r < NR; r++) begin
        send(r, 32'h2000_0000 + 32'(r * 16 + k), tile_id_t'(r + 4), 1'b1, 0);
        expect_beat(r, 32'h2000_0000 + 32'(r * 16 + k), tile_id_t'(r + 4));
      end
    end
    cyc = 0;
    while (!s_wvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t2_start", 64'(s_wvalid), 1);
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      check_eq("t2_b2b", 64'(s_wvalid), 1);
    end
    wait_idle("t2");
    check_eq("t2_stall", 64'(stall_cycles), 0);

    // Three-beat message from 2 is not interleaved with requester 1
    do_reset();
    send(2, 32'h3000_00A0, 4'd2, 1'b0, 0);
    send(2, 32'h3000_00B0, 4'd2, 1'b0, 0);
    send(2, 32'h3000_00C0, 4'd2, 1'b1, 0);
    send(1, 32'h3000_0011, 4'd8, 1'b1, 1);
    expect_beat(2, 32'h3000_00A0, 4'd2);
    expect_beat(2, 32'h3000_00B0, 4'd2);
    expect_beat(2, 32'h3000_00C0, 4'd2);
    expect_beat(1, 32'h3000_0011, 4'd8);
    wait_idle("t3");

    // Locked owner idles 5 cycles: requester 3 stays blocked, then wins right after
    do_reset();
    send(2, 32'h4000_00A0, 4'd3, 1'b0, 0);
    send(2, 32'h4000_00B0, 4'd3, 1'b1, 5);
    send(3, 32'h4000_0033, 4'd9, 1'b1, 1);
    expect_beat(2, 32'h4000_00A0, 4'd3);
    expect_beat(2, 32'h4000_00B0, 4'd3);
    expect_beat(3, 32'h4000_0033, 4'd9);
    cyc   = 0;
    cnt   = 0;
    found = 1'b0;
    while (!found && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (req_valid[3] && !req_ready[3]) cnt++;
      if (req_valid[2] && req_ready[2] && req_last[2]) found = 1'b1;
    end
    check_eq("t4_last_seen", 64'(found), 1);
    check_eq("t4_r3_blocked", 64'(cnt), 6);
    @(negedge clk);
    check_eq("t4_r3_next", 64'(req_ready), 64'(4'b1000));
    wait_idle("t4");

    // Ten stall cycles: held beat stable, no readies, then back-to-back release
    do_reset();
    s_wready = 1'b0;
    send(0, 32'h5555_0001, 4'd5, 1'b1, 0);
    send(1, 32'h5555_0002, 4'd6, 1'b1, 0);
    expect_beat(0, 32'h5555_0001, 4'd5);
    expect_beat(1, 32'h5555_0002, 4'd6);
    cyc = 0;
    while (!s_wvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t5_wvalid", 64'(s_wvalid), 1);
    check_eq("t5_stall0", 64'(stall_cycles), 0);
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check_eq("t5_hold_data", 64'(s_wdata), 64'(32'h5555_0001));
      check_eq("t5_hold_port", 64'(s_port), 5);
      check_eq("t5_no_ready", 64'(req_ready), 0);
    end
    @(posedge clk);
    #1;
    s_wready = 1'b1;
    @(negedge clk);
    check_eq("t5_stall10", 64'(stall_cycles), 10);
    check_eq("t5_ready1", 64'(req_ready), 64'(4'b0010));
    @(negedge clk);
    check_eq("t5_b2b_valid", 64'(s_wvalid), 1);
    check_eq("t5_b2b_grant", 64'(grant_id), 1);
    wait_idle("t5");
    check_eq("t5_stall_keep", 64'(stall_cycles), 10);

    // Reset while locked with a held beat: immediate clear, priority back to 0
    do_reset();
    s_wready = 1'b0;
    send(2, 32'h6000_00A0, 4'd9, 1'b0, 0);
    send(2, 32'h6000_00B0, 4'd9, 1'b1, 20);
    cyc = 0;
    while (!s_wvalid && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("t6_pre_wvalid", 64'(s_wvalid), 1);
    #1;
    rst = 1'b1;
    #1;
    check_eq("t6_async_wvalid", 64'(s_wvalid), 0);
    check_eq("t6_async_data", 64'(s_wdata), 0);
    check_eq("t6_async_grant", 64'(grant_id), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst      = 1'b0;
    s_wready = 1'b1;
    send(2, 32'h6000_0022, 4'd3, 1'b1, 0);
    send(0, 32'h6000_0000, 4'd7, 1'b1, 0);
    expect_beat(0, 32'h6000_0000, 4'd7);
    expect_beat(2, 32'h6000_0022, 4'd3);
    wait_idle("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
